tt_um_burst_ram: RTL and testbench

Parametrised byte-wide single-port RAM tile with an internal address pointer, strobe-qualified command interface and optional auto-increment for burst reads and writes. It succeeds the fixed 128-byte direct-address RAM tile. Addressing moves from input pins into a loadable pointer, which frees pins for an opcode, and depth becomes a parameter. It sits as a standalone TinyTapeout user tile driven from the dedicated inputs and bidirectional inputs.

---
 rtl/tt_um_burst_ram.sv | 161 ++++++++++++++++
 tb/tb_tt_um_burst_ram.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_burst_ram.sv
// tt_um_burst_ram: byte-wide single-port RAM tile with a loadable address
// pointer, strobe-qualified command interface and optional auto-increment
// for burst reads and writes.
// Optional feature macro: RAM_CLEAR_EN -- zero-fills memory after reset and
// blocks LOAD/WRITE/READ while the sweep runs.
module tt_um_burst_ram #(
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] OP_STATUS = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  logic [1:0]    op;
  logic          stb;
  logic          inc;
  logic          strb_q;
  logic [AW-1:0] ptr;
  logic [7:0]    uo_q;
  logic [7:0]    mem [DEPTH];

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  logic          fire;
  logic          cmd_ok;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [6:0]    ptr_ext;
  logic          unused_ok;

  assign op      = ui_in[7:6];
  assign stb     = ui_in[5];
  assign inc     = ui_in[0];
  assign ptr_ext = 7'(ptr);

  // A command fires only on a sampled low-to-high strobe transition; while
  // the clear sweep runs only STATUS is honoured, others are dropped.
  assign fire   = rst_n & stb & ~strb_q;
  assign cmd_ok = fire & (~busy | (op == OP_STATUS));

  assign uo_out  = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Power-good and the reserved opcode bits carry no meaning here.
  assign unused_ok = &{1'b0, ena, ui_in[4:1]};

`ifdef RAM_CLEAR_EN
  // S_START is the state held in reset; leaving it on the first non-reset
  // edge makes the sweep occupy exactly DEPTH cycles after release.
  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_CLEAR = 2'd1,
    S_IDLE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // State register; reset restarts the sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_START;
    else        state <= state_nxt;
  end

  // Next-state logic: start -> clear sweep -> idle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_START: state_nxt = S_CLEAR;
      S_CLEAR: if (clr_addr == AW'(DEPTH - 1)) state_nxt = S_IDLE;
      S_IDLE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: busy and the sweep write enable are the clear state.
  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    if (state == S_CLEAR) begin
      busy   = 1'b1;
      clr_we = 1'b1;
    end
  end

  // Sweep address walks 0..DEPTH-1 while clearing and restarts on reset.
  always_ff @(posedge clk) begin
    if (!rst_n)                clr_addr <= '0;
    else if (state == S_CLEAR) clr_addr <= clr_addr + AW'(1);
  end
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  // Strobe history; reset value 1 keeps a strobe held across release inert.
  always_ff @(posedge clk) begin
    if (!rst_n) strb_q <= 1'b1;
    else        strb_q <= stb;
  end

  // Address pointer: load, or post-increment (modulo DEPTH) on bursts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (cmd_ok) begin
      case (op)
        OP_LOAD:  ptr <= uio_in[AW-1:0];
        OP_WRITE: if (inc) ptr <= ptr + AW'(1);
        OP_READ:  if (inc) ptr <= ptr + AW'(1);
        default:  ptr <= ptr;
      endcase
    end
  end

  // Registered output byte: status word or read data, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uo_q <= 8'h00;
    end else if (cmd_ok) begin
      if (op == OP_STATUS)    uo_q <= {busy, ptr_ext};
      else if (op == OP_READ) uo_q <= mem[ptr];
    end
  end

  // Write-port select: the clear sweep owns the port while it runs.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = ptr;
    mem_wdata = uio_in;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = 8'h00;
    end else if (cmd_ok && (op == OP_WRITE)) begin
      mem_we = 1'b1;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

endmodule

// File: tb/tb_tt_um_burst_ram.sv
// Testbench for tt_um_burst_ram (DEPTH=128): directed vector table,
// hand-written multi-cycle sequences and randomized commands checked
// against a behavioural model of the RAM tile.
module tb_tt_um_burst_ram;

  localparam int DEPTH = 128;
  localparam logic [1:0] ST = 2'b00;
  localparam logic [1:0] LD = 2'b01;
  localparam logic [1:0] WR = 2'b10;
  localparam logic [1:0] RD = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int checks;
  int failures;

  // behavioural model state
  int         m_ptr;
  logic [7:0] m_uo;
  bit         m_known;
  logic [7:0] tb_mem [DEPTH];
  bit         tb_val [DEPTH];

  typedef struct {
    logic [1:0] op;
    logic       inc;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [18];

  tt_um_burst_ram #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h expected=%02h", name, got, exp);
    end
  endtask

  task automatic m_reset();
    m_ptr   = 0;
    m_uo    = 8'h00;
    m_known = 1'b1;
`ifdef RAM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i] = 8'h00;
      tb_val[i] = 1'b1;
    end
`endif
  endtask

  task automatic m_cmd(input logic [1:0] op, input logic inc, input logic [7:0] d);
    case (op)
      ST: begin
        m_uo    = 8'(m_ptr);
        m_known = 1'b1;
      end
      LD: m_ptr = d % DEPTH;
      WR: begin
        tb_mem[m_ptr] = d;
        tb_val[m_ptr] = 1'b1;
        if (inc) m_ptr = (m_ptr + 1) % DEPTH;
      end
      default: begin
        m_uo    = tb_mem[m_ptr];
        m_known = tb_val[m_ptr];
        if (inc) m_ptr = (m_ptr + 1) % DEPTH;
      end
    endcase
  endtask

  // One strobed command (high one cycle, low one cycle); returns uo_out
  // sampled just after the strobe edge and advances the model.
  task automatic cmd(input logic [1:0] op, input logic inc, input logic [7:0] d,
                     output logic [7:0] got);
    @(negedge clk);
    ui_in  = {op, 1'b1, 4'($urandom_range(0, 15)), inc};
    uio_in = d;
    @(posedge clk); #1;
    got = uo_out;
    @(negedge clk);
    ui_in[5] = 1'b0;
    uio_in   = 8'($urandom);
    @(posedge clk); #1;
    m_cmd(op, inc, d);
  endtask

  task automatic do_reset(input bit hold);
    @(negedge clk);
    rst_n = 1'b0;
    if (hold) begin
      ui_in  = {WR, 1'b1, 4'b0000, 1'b1};
      uio_in = 8'hEE;
    end else begin
      ui_in[5] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_uo_out", uo_out, 8'h00);
    if (hold) repeat (3) @(posedge clk);
    @(negedge clk);
    ui_in[5] = 1'b0;
    @(posedge clk); #1;
`ifdef RAM_CLEAR_EN
    repeat (DEPTH + 2) @(posedge clk);
    #1;
`endif
    m_reset();
  endtask

  initial begin
    logic [7:0] got;
    logic [1:0] rop;
    logic       rinc;
    logic [7:0] rd;

    checks   = 0;
    failures = 0;
    ena      = 1'b1;
    rst_n    = 1'b0;
    ui_in    = 8'h00;
    uio_in   = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i] = 8'h00;
      tb_val[i] = 1'b0;
    end

    tbl[0]  = '{ST, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{LD, 1'b0, 8'h10, 8'h00};
    tbl[2]  = '{WR, 1'b1, 8'hA5, 8'h00};
    tbl[3]  = '{WR, 1'b1, 8'h5A, 8'h00};
    tbl[4]  = '{LD, 1'b0, 8'h10, 8'h00};
    tbl[5]  = '{RD, 1'b1, 8'h00, 8'hA5};
    tbl[6]  = '{RD, 1'b1, 8'h00, 8'h5A};
    tbl[7]  = '{ST, 1'b0, 8'h00, 8'h12};
    tbl[8]  = '{LD, 1'b0, 8'h7F, 8'h12};
    tbl[9]  = '{WR, 1'b1, 8'h3C, 8'h12};
    tbl[10] = '{ST, 1'b0, 8'h00, 8'h00};
    tbl[11] = '{LD, 1'b0, 8'hFF, 8'h00};
    tbl[12] = '{ST, 1'b0, 8'h00, 8'h7F};
    tbl[13] = '{RD, 1'b0, 8'h00, 8'h3C};
    tbl[14] = '{LD, 1'b0, 8'h05, 8'h3C};
    tbl[15] = '{WR, 1'b0, 8'h11, 8'h3C};
    tbl[16] = '{RD, 1'b0, 8'h00, 8'h11};
    tbl[17] = '{ST, 1'b0, 8'h00, 8'h05};

    do_reset(1'b0);
    chk("uio_out_tied", uio_out, 8'h00);
    chk("uio_oe_tied", uio_oe, 8'h00);

    for (int i = 0; i < 18; i++) begin
      cmd(tbl[i].op, tbl[i].inc, tbl[i].d, got);
      chk($sformatf("vec%0d", i), got, tbl[i].exp);
    end

    // Strobe held high for 10 cycles: exactly one write with increment,
    // opcode/data wiggling meanwhile must not matter.
    cmd(LD, 1'b0, 8'h20, got);
    @(negedge clk);
    ui_in  = {WR, 1'b1, 4'b0000, 1'b1};
    uio_in = 8'h77;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ui_in[7:6] = 2'($urandom);
      uio_in     = 8'($urandom);
    end
    @(negedge clk);
    ui_in[5] = 1'b0;
    @(posedge clk); #1;
    m_cmd(WR, 1'b1, 8'h77);
    cmd(ST, 1'b0, 8'h00, got);
    chk("hold_status", got, 8'h21);
    cmd(LD, 1'b0, 8'h20, got);
    cmd(RD, 1'b0, 8'h00, got);
    chk("hold_read", got, 8'h77);
    cmd(RD, 1'b1, 8'h00, got);
    chk("hold_next_untouched", got, m_uo);

    // Reset mid-burst: pointer returns to 0, completed writes kept.
    cmd(LD, 1'b0, 8'h00, got);
    cmd(WR, 1'b1, 8'h42, got);
    cmd(WR, 1'b1, 8'hC3, got);
    do_reset(1'b1);
    cmd(ST, 1'b0, 8'h00, got);
    chk("held_reset_status", got, 8'h00);
    cmd(RD, 1'b1, 8'h00, got);
`ifdef RAM_CLEAR_EN
    chk("held_reset_read0", got, 8'h00);
`else
    chk("held_reset_read0", got, 8'h42);
`endif
    cmd(RD, 1'b0, 8'h00, got);
`ifdef RAM_CLEAR_EN
    chk("burst_kept_read1", got, 8'h00);
`else
    chk("burst_kept_read1", got, 8'hC3);
`endif

`ifdef RAM_CLEAR_EN
    // Busy window after release, dropped write, and reset during the sweep.
    cmd(LD, 1'b0, 8'h03, got);
    cmd(WR, 1'b0, 8'hFF, got);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmd(ST, 1'b0, 8'h00, got);
    chk("clear_busy_status", got, 8'h80);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmd(WR, 1'b0, 8'h55, got);
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    m_reset();
    cmd(ST, 1'b0, 8'h00, got);
    chk("clear_done_status", got, 8'h00);
    cmd(RD, 1'b0, 8'h00, got);
    chk("clear_dropped_write", got, 8'h00);
    cmd(LD, 1'b0, 8'h03, got);
    cmd(RD, 1'b0, 8'h00, got);
    chk("clear_addr3", got, 8'h00);
`endif

    // Randomized commands against the model, with random strobe gaps.
    for (int n = 0; n < 400; n++) begin
      rop  = 2'($urandom);
      rinc = 1'($urandom);
      rd   = 8'($urandom);
      cmd(rop, rinc, rd, got);
      if (m_known) chk($sformatf("rand%0d_op%0d", n, rop), got, m_uo);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
